// File: rtl/fpga_mem_pkg.sv
// Shared definitions for the FPGA memory models: lane width, clear-FSM
// state encoding and the per-lane write merge.
package fpga_mem_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // A lane keeps its old byte when its active-low enable is high.
    function automatic logic [LANE_W-1:0] lane_merge(
        input logic [LANE_W-1:0] old_lane,
        input logic [LANE_W-1:0] new_lane,
        input logic              bwen_n
    );
        return bwen_n ? old_lane : new_lane;
    endfunction

endpackage

// File: rtl/fpga_bwe_spram_if.sv
// Access bus of the byte-write-enable SPRAM. The requester drives the
// address, controls and data; the RAM returns read data, its valid flag and BUSY.
interface fpga_bwe_spram_if #(
    parameter int ADDRWIDTH = 15,
    parameter int NUM_BYTES = 4
);
    localparam int DATAWIDTH = fpga_mem_pkg::LANE_W * NUM_BYTES;

    logic [ADDRWIDTH-1:0] A;
    logic                 CEN;
    logic                 WEN;
    logic [NUM_BYTES-1:0] BWEN;
    logic [DATAWIDTH-1:0] D;
    logic                 CLR;
    logic [DATAWIDTH-1:0] Q;
    logic                 QVALID;
    logic                 BUSY;

    modport master (
        output A, CEN, WEN, BWEN, D, CLR,
        input  Q, QVALID, BUSY
    );

    modport slave (
        input  A, CEN, WEN, BWEN, D, CLR,
        output Q, QVALID, BUSY
    );

endinterface

// File: rtl/fpga_mem_clr_ctrl.sv
// Clear engine: sweeps every word once after reset release or on request,
// presenting one write address per cycle while BUSY is high.
module fpga_mem_clr_ctrl
    import fpga_mem_pkg::*;
#(
    parameter int ADDRWIDTH  = 15,
    parameter int MEMDEPTH   = 2**ADDRWIDTH,
    parameter int CLR_ON_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDRWIDTH-1:0] clr_addr
);

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMDEPTH - 1);

    clr_state_e           state_q, state_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic                 rst_seen_q, rst_seen_d;

    // State, sweep counter and the "just left reset" marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {ADDRWIDTH{1'b0}};
            rst_seen_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_seen_q <= rst_seen_d;
        end
    end

    // Next-state logic; a request arriving during a sweep is ignored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_seen_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {ADDRWIDTH{1'b0}};
                if (((CLR_ON_RST != 0) && rst_seen_q) || clr_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDRWIDTH{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + ADDRWIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDRWIDTH{1'b0}};
            end
        endcase
    end

    // Reset forces BUSY low immediately so an aborted sweep never writes.
    assign busy     = (state_q == ST_CLEAR) && !rst;
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/fpga_bwe_spram.sv
// Single-port synchronous RAM with per-byte write enables, write-through,
// optional output register and a built-in clear sweep.
module fpga_bwe_spram
    import fpga_mem_pkg::*;
#(
    parameter int         ADDRWIDTH  = 15,
    parameter int         NUM_BYTES  = 4,
    parameter int         MEMDEPTH   = 2**ADDRWIDTH,
    parameter int         OUT_REG    = 0,
    parameter int         CLR_ON_RST = 1,
    parameter logic [7:0] CLR_VALUE  = 8'h00
) (
    input  logic                   CLK,
    input  logic                   RST,
    fpga_bwe_spram_if.slave        bus
);

    localparam int DATAWIDTH = LANE_W * NUM_BYTES;
    localparam logic [ADDRWIDTH:0] DEPTH_W = (ADDRWIDTH + 1)'(MEMDEPTH);

    logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

    logic                 busy_s;
    logic                 clr_we_s;
    logic [ADDRWIDTH-1:0] clr_addr_s;
    logic                 accept_s;
    logic                 in_range_s;
    logic                 wr_en_s;
    logic [DATAWIDTH-1:0] old_word_s;
    logic [DATAWIDTH-1:0] merged_s;

    logic [DATAWIDTH-1:0] s1_data_q, s1_data_d;
    logic                 s1_vld_q, s1_vld_d;

    fpga_mem_clr_ctrl #(
        .ADDRWIDTH  (ADDRWIDTH),
        .MEMDEPTH   (MEMDEPTH),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr_ctrl (
        .clk      (CLK),
        .rst      (RST),
        .clr_req  (bus.CLR),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    assign bus.BUSY = busy_s;

    // Access decode, lane merge and stage-1 next values.
    always_comb begin
        accept_s   = !bus.CEN && !busy_s && !RST;
        in_range_s = {1'b0, bus.A} < DEPTH_W;
        old_word_s = in_range_s ? mem_q[bus.A] : {DATAWIDTH{1'b0}};
        merged_s   = {DATAWIDTH{1'b0}};
        for (int i = 0; i < NUM_BYTES; i++) begin
            merged_s[i*LANE_W +: LANE_W] = lane_merge(old_word_s[i*LANE_W +: LANE_W],
                                                      bus.D[i*LANE_W +: LANE_W],
                                                      bus.BWEN[i]);
        end
        wr_en_s  = accept_s && !bus.WEN && in_range_s;
        s1_vld_d = accept_s;
        if (accept_s) begin
            s1_data_d = bus.WEN ? old_word_s : (in_range_s ? merged_s : {DATAWIDTH{1'b0}});
        end else begin
            s1_data_d = s1_data_q;
        end
    end

    // Array write port; the clear sweep owns it while BUSY.
    always_ff @(posedge CLK) begin
        if (clr_we_s) begin
            mem_q[clr_addr_s] <= {NUM_BYTES{CLR_VALUE}};
        end else if (wr_en_s) begin
            mem_q[bus.A] <= merged_s;
        end
    end

    // First output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_data_q <= {DATAWIDTH{1'b0}};
            s1_vld_q  <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAWIDTH-1:0] s2_data_q, s2_data_d;
        logic                 s2_vld_q, s2_vld_d;

        // Second stage holds Q unless stage 1 carries a fresh access.
        always_comb begin
            s2_vld_d  = s1_vld_q;
            s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
        end

        // Second output stage register.
        always_ff @(posedge CLK) begin
            if (RST) begin
                s2_data_q <= {DATAWIDTH{1'b0}};
                s2_vld_q  <= 1'b0;
            end else begin
                s2_data_q <= s2_data_d;
                s2_vld_q  <= s2_vld_d;
            end
        end

        assign bus.Q      = s2_data_q;
        assign bus.QVALID = s2_vld_q;
    end else begin : g_no_out_reg
        assign bus.Q      = s1_data_q;
        assign bus.QVALID = s1_vld_q;
    end

endmodule

// File: tb/tb_fpga_bwe_spram.sv
// Directed bench for fpga_bwe_spram: three instances cover the clear sweep,
// byte writes, the output register and out-of-range addressing.
module tb_fpga_bwe_spram;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   failed;
    int   n0, n1, n2, busy_n;

    fpga_bwe_spram_if #(.ADDRWIDTH(4), .NUM_BYTES(4)) b0 ();
    fpga_bwe_spram_if #(.ADDRWIDTH(4), .NUM_BYTES(4)) b1 ();
    fpga_bwe_spram_if #(.ADDRWIDTH(4), .NUM_BYTES(4)) b2 ();

    fpga_bwe_spram #(.ADDRWIDTH(4), .NUM_BYTES(4), .MEMDEPTH(16), .OUT_REG(0),
                     .CLR_ON_RST(1), .CLR_VALUE(8'hA5))
        dut0 (.CLK(clk), .RST(rst), .bus(b0));
    fpga_bwe_spram #(.ADDRWIDTH(4), .NUM_BYTES(4), .MEMDEPTH(16), .OUT_REG(1),
                     .CLR_ON_RST(1), .CLR_VALUE(8'h00))
        dut1 (.CLK(clk), .RST(rst), .bus(b1));
    fpga_bwe_spram #(.ADDRWIDTH(4), .NUM_BYTES(4), .MEMDEPTH(12), .OUT_REG(0),
                     .CLR_ON_RST(1), .CLR_VALUE(8'h00))
        dut2 (.CLK(clk), .RST(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst = 1'b1;
        b0.A = 4'd0; b0.CEN = 1'b1; b0.WEN = 1'b1; b0.BWEN = 4'hF; b0.D = 32'h0; b0.CLR = 1'b0;
        b1.A = 4'd0; b1.CEN = 1'b1; b1.WEN = 1'b1; b1.BWEN = 4'hF; b1.D = 32'h0; b1.CLR = 1'b0;
        b2.A = 4'd0; b2.CEN = 1'b1; b2.WEN = 1'b1; b2.BWEN = 4'hF; b2.D = 32'h0; b2.CLR = 1'b0;
        tick(); tick();
        check("rst_q",      b0.Q, 32'h0);
        check("rst_qvalid", {31'd0, b0.QVALID}, 32'd0);
        check("rst_busy",   {31'd0, b0.BUSY}, 32'd0);

        // reset-release sweep length on every instance
        rst = 1'b0;
        n0 = 0; n1 = 0; n2 = 0;
        repeat (30) begin
            tick();
            n0 += int'(b0.BUSY); n1 += int'(b1.BUSY); n2 += int'(b2.BUSY);
        end
        check("sweep_len0", n0, 32'd16);
        check("sweep_len1", n1, 32'd16);
        check("sweep_len2", n2, 32'd12);

        // read after clear
        b0.A = 4'd7; b0.CEN = 1'b0; b0.WEN = 1'b1;
        tick();
        check("rd7_q",      b0.Q, 32'hA5A5A5A5);
        check("rd7_qvalid", {31'd0, b0.QVALID}, 32'd1);
        b0.CEN = 1'b1;
        tick();
        check("idle_qvalid", {31'd0, b0.QVALID}, 32'd0);
        check("idle_hold",   b0.Q, 32'hA5A5A5A5);

        // byte-lane writes with write-through
        b0.A = 4'd3; b0.CEN = 1'b0; b0.WEN = 1'b0; b0.BWEN = 4'b0000; b0.D = 32'h11223344;
        tick();
        check("wr_full_q", b0.Q, 32'h11223344);
        b0.BWEN = 4'b1010; b0.D = 32'hDEADBEEF;
        tick();
        check("wr_byte_q", b0.Q, 32'h11AD33EF);
        b0.WEN = 1'b1; b0.BWEN = 4'hF; b0.D = 32'h0;
        tick();
        check("rd3_q", b0.Q, 32'h11AD33EF);
        b0.WEN = 1'b0; b0.BWEN = 4'b1111; b0.D = 32'h00000000;
        tick();
        check("noop_wr_q",      b0.Q, 32'h11AD33EF);
        check("noop_wr_qvalid", {31'd0, b0.QVALID}, 32'd1);
        b0.WEN = 1'b1;
        tick();
        check("noop_rd3_q", b0.Q, 32'h11AD33EF);

        // read immediately after write to the same address
        b0.A = 4'd4; b0.WEN = 1'b0; b0.BWEN = 4'b0000; b0.D = 32'hCAFEF00D;
        tick();
        b0.WEN = 1'b1; b0.BWEN = 4'hF; b0.D = 32'h0;
        tick();
        check("raw_q", b0.Q, 32'hCAFEF00D);
        b0.CEN = 1'b1;

        // CLR sweep: dropped write, ignored second CLR
        b0.CLR = 1'b1;
        tick();
        b0.CLR = 1'b0;
        check("clr_busy", {31'd0, b0.BUSY}, 32'd1);
        busy_n = 1;
        repeat (6) begin tick(); busy_n += int'(b0.BUSY); end
        b0.A = 4'd5; b0.CEN = 1'b0; b0.WEN = 1'b0; b0.BWEN = 4'b0000; b0.D = 32'h12345678;
        tick(); busy_n += int'(b0.BUSY);
        check("busy_qvalid", {31'd0, b0.QVALID}, 32'd0);
        check("busy_q_hold", b0.Q, 32'hCAFEF00D);
        b0.CEN = 1'b1; b0.WEN = 1'b1; b0.BWEN = 4'hF; b0.D = 32'h0;
        tick(); busy_n += int'(b0.BUSY);
        b0.CLR = 1'b1;
        tick(); busy_n += int'(b0.BUSY);
        b0.CLR = 1'b0;
        repeat (20) begin tick(); busy_n += int'(b0.BUSY); end
        check("clr_sweep_len", busy_n, 32'd16);
        b0.A = 4'd5; b0.CEN = 1'b0;
        tick();
        check("rd5_cleared", b0.Q, 32'hA5A5A5A5);

        // reset in the middle of a sweep
        b0.A = 4'd9; b0.WEN = 1'b0; b0.BWEN = 4'b0000; b0.D = 32'h99999999;
        tick();
        b0.CEN = 1'b1; b0.WEN = 1'b1; b0.BWEN = 4'hF;
        b0.CLR = 1'b1;
        tick();
        b0.CLR = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy_comb", {31'd0, b0.BUSY}, 32'd0);
        tick();
        check("midrst_q",      b0.Q, 32'h0);
        check("midrst_qvalid", {31'd0, b0.QVALID}, 32'd0);
        check("midrst_busy",   {31'd0, b0.BUSY}, 32'd0);
        rst = 1'b0;
        n0 = 0;
        repeat (30) begin tick(); n0 += int'(b0.BUSY); end
        check("restart_len", n0, 32'd16);
        b0.A = 4'd9; b0.CEN = 1'b0;
        tick();
        check("rd9_restart_cleared", b0.Q, 32'hA5A5A5A5);
        b0.CEN = 1'b1;

        // OUT_REG=1 streaming
        b1.CEN = 1'b0; b1.WEN = 1'b0; b1.BWEN = 4'b0000;
        b1.A = 4'd0; b1.D = 32'h10; tick();
        b1.A = 4'd1; b1.D = 32'h20; tick();
        b1.A = 4'd2; b1.D = 32'h30; tick();
        b1.WEN = 1'b1; b1.BWEN = 4'hF; b1.D = 32'h0;
        b1.A = 4'd0; tick();
        b1.A = 4'd1; tick();
        check("oreg_q0", b1.Q, 32'h10);
        check("oreg_v0", {31'd0, b1.QVALID}, 32'd1);
        b1.A = 4'd2; tick();
        check("oreg_q1", b1.Q, 32'h20);
        check("oreg_v1", {31'd0, b1.QVALID}, 32'd1);
        b1.CEN = 1'b1; tick();
        check("oreg_q2", b1.Q, 32'h30);
        check("oreg_v2", {31'd0, b1.QVALID}, 32'd1);
        tick();
        check("oreg_idle_v",    {31'd0, b1.QVALID}, 32'd0);
        check("oreg_idle_hold", b1.Q, 32'h30);

        // out-of-range addressing with MEMDEPTH=12
        b2.CEN = 1'b0; b2.WEN = 1'b0; b2.BWEN = 4'b0000;
        b2.A = 4'd0;  b2.D = 32'hAAAAAAAA; tick();
        b2.A = 4'd11; b2.D = 32'hBBBBBBBB; tick();
        b2.D = 32'hFFFFFFFF;
        b2.A = 4'd13; tick();
        check("oor_wr_qvalid", {31'd0, b2.QVALID}, 32'd1);
        b2.A = 4'd12; tick();
        b2.A = 4'd15; tick();
        b2.WEN = 1'b1; b2.BWEN = 4'hF; b2.D = 32'h0;
        b2.A = 4'd13; tick();
        check("oor_rd13_q",      b2.Q, 32'h0);
        check("oor_rd13_qvalid", {31'd0, b2.QVALID}, 32'd1);
        b2.A = 4'd12; tick();
        check("oor_rd12_q", b2.Q, 32'h0);
        b2.A = 4'd0; tick();
        check("oor_rd0_q", b2.Q, 32'hAAAAAAAA);
        b2.A = 4'd11; tick();
        check("oor_rd11_q", b2.Q, 32'hBBBBBBBB);
        b2.A = 4'd1; tick();
        check("oor_rd1_q", b2.Q, 32'h0);
        b2.A = 4'd3; tick();
        check("oor_rd3_q", b2.Q, 32'h0);
        b2.CEN = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
